// File: rtl/mux_nto1_stream_if.sv
// ============================================================================
// Module   : mux_nto1_stream_if
// Brief    : Handshake bundle for the N:1 stream mux: N producer channels in,
//            one registered consumer stream out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mux_nto1_stream_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
);
  logic [NUM_CH*WIDTH-1:0] i_data;
  logic [NUM_CH-1:0]       i_valid;
  logic [NUM_CH-1:0]       o_ready;
  logic [SEL_W-1:0]        i_sel;
  logic [WIDTH-1:0]        o_data;
  logic                    o_valid;
  logic                    i_ready;
  logic [SEL_W-1:0]        o_ch;

  // master = producers/consumer side, slave = the mux itself
  modport master (
    output i_data, i_valid, i_sel, i_ready,
    input  o_ready, o_data, o_valid, o_ch
  );

  modport slave (
    input  i_data, i_valid, i_sel, i_ready,
    output o_ready, o_data, o_valid, o_ch
  );
endinterface

`default_nettype wire

// File: rtl/mux_nto1_stream.sv
// ============================================================================
// Module   : mux_nto1_stream
// Brief    : N-channel valid/ready stream mux (explicit select or round-robin)
//            feeding one registered output stage with backpressure.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_nto1_stream #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int MODE   = 0,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  mux_nto1_stream_if.slave  bus
);

  logic              load_en;
  logic [SEL_W-1:0]  grant;
  logic              grant_valid;
  logic [WIDTH-1:0]  sel_data;
  logic [NUM_CH-1:0] ready;
  logic              in_xfer;

  logic [WIDTH-1:0]  data_q, data_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic              valid_q, valid_d;

  assign load_en = !valid_q || bus.i_ready;

  generate
    if (MODE == 0) begin : g_sel
      logic [SEL_W:0] sel_ext;
      assign sel_ext     = {1'b0, bus.i_sel};
      assign grant       = bus.i_sel;
      assign grant_valid = (sel_ext < (SEL_W+1)'(NUM_CH));
    end else begin : g_rr
      logic [SEL_W-1:0] ptr_q, ptr_d;
      logic             unused_sel;
      assign unused_sel = ^bus.i_sel;

      // first valid channel strictly after the last granted one
      always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_valid = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
          idx = (int'(ptr_q) + i) % NUM_CH;
          if (!grant_valid && bus.i_valid[idx]) begin
            grant       = SEL_W'(idx);
            grant_valid = 1'b1;
          end
        end
      end

      assign ptr_d = in_xfer ? grant : ptr_q;

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) ptr_q <= SEL_W'(NUM_CH - 1);
        else         ptr_q <= ptr_d;
      end
    end
  endgenerate

  // out-of-range grants match no channel, so they neither select data nor raise ready
  always_comb begin
    ready    = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant == SEL_W'(k)) begin
        sel_data = bus.i_data[k*WIDTH +: WIDTH];
        ready[k] = !i_reset && load_en && grant_valid;
      end
    end
  end

  assign in_xfer = |(bus.i_valid & ready);

  always_comb begin
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    if (in_xfer) begin
      data_d  = sel_data;
      ch_d    = grant;
      valid_d = 1'b1;
    end else if (bus.i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_data  = data_q;
  assign bus.o_ch    = ch_q;
  assign bus.o_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_nto1_stream.sv
// ============================================================================
// Module   : tb_mux_nto1_stream
// Brief    : Directed bench: explicit select (4 and 3 channels) and round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_nto1_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  mux_nto1_stream_if #(.WIDTH(32), .NUM_CH(4)) bus0 ();
  mux_nto1_stream_if #(.WIDTH(32), .NUM_CH(3)) bus3 ();
  mux_nto1_stream_if #(.WIDTH(32), .NUM_CH(4)) bus1 ();

  mux_nto1_stream #(.WIDTH(32), .NUM_CH(4), .MODE(0)) u_sel4 (
    .i_clk(clk), .i_reset(rst), .bus(bus0.slave));
  mux_nto1_stream #(.WIDTH(32), .NUM_CH(3), .MODE(0)) u_sel3 (
    .i_clk(clk), .i_reset(rst), .bus(bus3.slave));
  mux_nto1_stream #(.WIDTH(32), .NUM_CH(4), .MODE(1)) u_rr (
    .i_clk(clk), .i_reset(rst), .bus(bus1.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus0.i_data = '0; bus0.i_valid = '0; bus0.i_sel = '0; bus0.i_ready = 1'b0;
    bus3.i_data = '0; bus3.i_valid = '0; bus3.i_sel = '0; bus3.i_ready = 1'b0;
    bus1.i_data = '0; bus1.i_valid = '0; bus1.i_sel = '0; bus1.i_ready = 1'b0;
    #1;
    check("rst_o_valid", 64'(bus0.o_valid), 64'd0);
    check("rst_o_data",  64'(bus0.o_data),  64'd0);
    check("rst_o_ch",    64'(bus0.o_ch),    64'd0);
    check("rst_o_ready", 64'(bus0.o_ready), 64'd0);
    check("rst_rr_ready", 64'(bus1.o_ready), 64'd0);
    step();
    rst = 1'b0;
    #1;

    // explicit select, ch2
    bus0.i_sel = 2'd2; bus0.i_valid = 4'b0100; bus0.i_ready = 1'b1;
    bus0.i_data[2*32 +: 32] = 32'hDEAD_BEEF;
    #1;
    check("sel2_o_ready", 64'(bus0.o_ready), 64'b0100);
    step();
    bus0.i_valid = 4'b0000;
    check("sel2_o_valid", 64'(bus0.o_valid), 64'd1);
    check("sel2_o_data",  64'(bus0.o_data),  64'hDEAD_BEEF);
    check("sel2_o_ch",    64'(bus0.o_ch),    64'd2);
    step();
    check("drain_o_valid", 64'(bus0.o_valid), 64'd0);
    check("drain_o_data_hold", 64'(bus0.o_data), 64'hDEAD_BEEF);

    // backpressure with select change during stall
    bus0.i_sel = 2'd0; bus0.i_valid = 4'b0001;
    bus0.i_data[0 +: 32] = 32'hA5A5_0001;
    step();
    check("bp_load_data", 64'(bus0.o_data), 64'hA5A5_0001);
    bus0.i_ready = 1'b0; bus0.i_sel = 2'd1; bus0.i_valid = 4'b0010;
    bus0.i_data[1*32 +: 32] = 32'h1111_0001;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_o_ready", 64'(bus0.o_ready), 64'd0);
      step();
      check("bp_o_data", 64'(bus0.o_data), 64'hA5A5_0001);
      check("bp_o_ch",   64'(bus0.o_ch),   64'd0);
      check("bp_o_valid", 64'(bus0.o_valid), 64'd1);
    end
    bus0.i_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus0.o_ready), 64'b0010);
    step();
    bus0.i_valid = 4'b0000;
    check("bp_next_valid", 64'(bus0.o_valid), 64'd1);
    check("bp_next_data",  64'(bus0.o_data),  64'h1111_0001);
    check("bp_next_ch",    64'(bus0.o_ch),    64'd1);
    step();
    check("bp_drain_valid", 64'(bus0.o_valid), 64'd0);

    // out-of-range select on a 3-channel mux
    bus3.i_sel = 2'd3; bus3.i_valid = 3'b111; bus3.i_ready = 1'b1;
    bus3.i_data = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    #1;
    check("oor_o_ready", 64'(bus3.o_ready), 64'd0);
    step();
    check("oor_o_valid", 64'(bus3.o_valid), 64'd0);
    bus3.i_sel = 2'd2;
    #1;
    check("sel3_last_ready", 64'(bus3.o_ready), 64'b100);
    step();
    bus3.i_valid = 3'b000;
    check("sel3_last_data", 64'(bus3.o_data), 64'h3333_0002);

    // round-robin fairness
    bus1.i_data = {32'd3, 32'd2, 32'd1, 32'd0};
    bus1.i_valid = 4'b1111; bus1.i_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      check("rr_o_ch",    64'(bus1.o_ch),    64'(c % 4));
      check("rr_o_data",  64'(bus1.o_data),  64'(c % 4));
      check("rr_o_valid", 64'(bus1.o_valid), 64'd1);
    end
    bus1.i_valid = 4'b0000;
    step();
    check("rr_idle_valid", 64'(bus1.o_valid), 64'd0);

    // sparse requests and pointer wrap (pointer now at 3)
    bus1.i_valid = 4'b0100;
    #1;
    check("rr_sparse_ready", 64'(bus1.o_ready), 64'b0100);
    step();
    check("rr_sparse_ch", 64'(bus1.o_ch), 64'd2);
    bus1.i_valid = 4'b1010;
    #1;
    check("rr_1or3_ready", 64'(bus1.o_ready), 64'b1000);
    step();
    check("rr_1or3_ch", 64'(bus1.o_ch), 64'd3);
    bus1.i_valid = 4'b0010;
    #1;
    check("rr_wrap_ready", 64'(bus1.o_ready), 64'b0010);
    step();
    check("rr_wrap_ch", 64'(bus1.o_ch), 64'd1);

    // reset mid-stall; round-robin pointer sits at 1 beforehand
    bus0.i_sel = 2'd0; bus0.i_valid = 4'b0001; bus0.i_ready = 1'b1;
    bus0.i_data[0 +: 32] = 32'h1234_5678;
    bus1.i_valid = 4'b1111; bus1.i_ready = 1'b0;
    step();
    check("mr_load_data", 64'(bus0.o_data), 64'h1234_5678);
    bus0.i_ready = 1'b0;
    step();
    check("mr_stall_valid", 64'(bus0.o_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_o_valid", 64'(bus0.o_valid), 64'd0);
    check("mr_o_data",  64'(bus0.o_data),  64'd0);
    check("mr_o_ready", 64'(bus0.o_ready), 64'd0);
    check("mr_rr_ready", 64'(bus1.o_ready), 64'd0);
    #2;
    rst = 1'b0;
    #1;
    check("mr_post_ready", 64'(bus0.o_ready), 64'b0001);
    check("mr_rr_first_ready", 64'(bus1.o_ready), 64'b0001);
    step();
    check("mr_post_data", 64'(bus0.o_data), 64'h1234_5678);
    check("mr_rr_first_ch", 64'(bus1.o_ch), 64'd0);
    check("mr_rr_first_valid", 64'(bus1.o_valid), 64'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
